// File: rtl/snn_layer_engine.sv
// Spiking layer engine: nibble-sum features -> spikes -> shift-weighted saturating neuron sums -> argmax.
// Optional SNN_SPIKE_SKIP_EN skips fetching weight words whose inputs did not spike.
module snn_layer_engine #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 2,
  parameter int IN_W    = 8,
  parameter int WW      = 4,
  parameter int DW      = 8,
  parameter int ACC_W   = 12,
  parameter int ADDR_W  = 6,
  parameter int TH      = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [N_IN*IN_W-1:0]                        in_vec,
  output logic                                        w_req,
  output logic [ADDR_W-1:0]                           w_addr,
  input  logic                                        w_valid,
  input  logic [DW-1:0]                               w_data,
  output logic                                        busy,
  output logic [N_IN-1:0]                             spike_out,
  output logic [N_OUT*ACC_W-1:0]                      acc_out,
  output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] prediction,
  output logic                                        err,
  output logic                                        done
);
  localparam int WPW   = DW / WW;
  localparam int NW    = (N_IN * N_OUT + WPW - 1) / WPW;
  localparam int PW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SHW   = ACC_W + 2 ** (WW - 1);
  localparam int SUM_W = ACC_W + $clog2(WPW + 2);
  localparam int TCW   = $clog2(TIMEOUT + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_L1, S_REQ, S_WAIT, S_ARG, S_DONE} state_t;

  state_t                  r_state;
  logic [N_IN*IN_W-1:0]    r_in;
  logic [ACC_W-1:0]        r_feat [N_IN];
  logic [N_IN-1:0]         r_spike;
  logic [ACC_W-1:0]        r_acc [N_OUT];
  logic [PW-1:0]           r_pred;
  logic [ADDR_W-1:0]       r_word;
  logic [ADDR_W-1:0]       r_addr;
  logic [TCW-1:0]          r_wcnt;
  logic                    r_req, r_busy, r_err, r_done;

  logic [ACC_W-1:0]        w_feat [N_IN];
  logic [N_IN-1:0]         w_spike;
  logic [NW-1:0]           w_need;
  logic                    w_first_found, w_next_found;
  logic [ADDR_W-1:0]       w_first, w_next;
  logic [SUM_W-1:0]        w_sum [N_OUT];
  logic [ACC_W-1:0]        w_acc_next [N_OUT];
  logic [ACC_W-1:0]        w_best;
  logic [PW-1:0]           w_pred;

  // Positive shifts are done wide and clamped; negative shifts are logical right shifts.
  function automatic logic [ACC_W-1:0] sat_shift(input logic [ACC_W-1:0] x,
                                                 input logic signed [WW-1:0] w);
    logic [SHW-1:0] wide;
    logic [WW:0]    mag;
    wide = '0;
    mag  = '0;
    if (!w[WW-1]) begin
      wide = SHW'(x) << w[WW-2:0];
      sat_shift = (|wide[SHW-1:ACC_W]) ? ACC_MAX : wide[ACC_W-1:0];
    end else begin
      mag = -{w[WW-1], w};
      sat_shift = x >> mag;
    end
  endfunction

  function automatic logic [ACC_W-1:0] sat_acc(input logic [SUM_W-1:0] s);
    sat_acc = (|s[SUM_W-1:ACC_W]) ? ACC_MAX : s[ACC_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_feat[i]  = ACC_W'(r_in[i*IN_W +: IN_W/2]) + ACC_W'(r_in[i*IN_W + IN_W/2 +: IN_W/2]);
      w_spike[i] = w_feat[i] > ACC_W'(TH);
    end
  end

  always_comb begin
    w_need = '0;
    for (int i = 0; i < N_IN; i++) begin
      for (int j = 0; j < N_OUT; j++) begin
`ifdef SNN_SPIKE_SKIP_EN
        w_need[(i*N_OUT+j)/WPW] = w_need[(i*N_OUT+j)/WPW] | w_spike[i];
`else
        w_need[(i*N_OUT+j)/WPW] = 1'b1;
`endif
      end
    end
  end

  // Descending scan leaves the lowest qualifying word index in each result.
  always_comb begin
    w_first_found = 1'b0;
    w_first       = '0;
    w_next_found  = 1'b0;
    w_next        = '0;
    for (int n = NW - 1; n >= 0; n--) begin
      if (w_need[n]) begin
        w_first_found = 1'b1;
        w_first       = ADDR_W'(n);
        if (n > int'(r_word)) begin
          w_next_found = 1'b1;
          w_next       = ADDR_W'(n);
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) w_sum[j] = SUM_W'(r_acc[j]);
    for (int i = 0; i < N_IN; i++) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (int'(r_word) == (i*N_OUT+j)/WPW && r_spike[i])
          w_sum[j] = w_sum[j] + SUM_W'(sat_shift(r_feat[i],
                       w_data[DW-1-((i*N_OUT+j)%WPW)*WW -: WW]));
      end
    end
    for (int j = 0; j < N_OUT; j++) w_acc_next[j] = sat_acc(w_sum[j]);
  end

  always_comb begin
    w_pred = '0;
    w_best = r_acc[0];
    for (int j = 1; j < N_OUT; j++) begin
      if (r_acc[j] > w_best) begin
        w_best = r_acc[j];
        w_pred = PW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) r_in <= in_vec;
    if (r_state == S_L1)
      for (int i = 0; i < N_IN; i++) r_feat[i] <= w_feat[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_spike <= '0;
      r_pred  <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_word  <= '0;
      r_wcnt  <= '0;
      for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
          r_err   <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_L1;
        end
        S_L1: begin
          r_spike <= w_spike;
          if (w_first_found) begin
            r_word  <= w_first;
            r_addr  <= w_first;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else begin
            r_state <= S_ARG;
          end
        end
        S_REQ: begin
          r_req   <= 1'b0;
          r_addr  <= '0;
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (w_valid) begin
          for (int j = 0; j < N_OUT; j++) r_acc[j] <= w_acc_next[j];
          if (w_next_found) begin
            r_word  <= w_next;
            r_addr  <= w_next;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else begin
            r_state <= S_ARG;
          end
        end else if (r_wcnt == TCW'(TIMEOUT - 1)) begin
          for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
          r_err   <= 1'b1;
          r_pred  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
        S_ARG: begin
          r_pred  <= w_pred;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_req      = r_req;
  assign w_addr     = r_addr;
  assign busy       = r_busy;
  assign spike_out  = r_spike;
  assign prediction = r_pred;
  assign err        = r_err;
  assign done       = r_done;

  for (genvar j = 0; j < N_OUT; j++) begin : g_acc
    assign acc_out[j*ACC_W +: ACC_W] = r_acc[j];
  end

endmodule

// File: tb/tb_snn_layer_engine.sv
// Randomized bench for snn_layer_engine with a behavioural model of the layer and a simple weight memory.
module tb_snn_layer_engine;
  localparam int N_IN = 4, N_OUT = 2, IN_W = 8, ACC_W = 12, ADDR_W = 6;
  localparam int WPW = 2, NW = (N_IN * N_OUT + WPW - 1) / WPW;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst, start;
  logic [N_IN*IN_W-1:0]    in_vec;
  logic                    w_req, w_valid;
  logic [ADDR_W-1:0]       w_addr;
  logic [7:0]              w_data;
  logic                    busy, err, done;
  logic [N_IN-1:0]         spike_out;
  logic [N_OUT*ACC_W-1:0]  acc_out;
  logic [0:0]              prediction;

  int         n_chk = 0, n_err = 0;
  logic [7:0] mem [64];
  bit         mem_on;
  int         mem_dly;
  int         req_log [$];

  logic [31:0] m_in;
  int          e_acc [N_OUT];
  int          e_pred, e_spk, e_lat;
  int          e_addr [$];

  snn_layer_engine dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
    .w_req(w_req), .w_addr(w_addr), .w_valid(w_valid), .w_data(w_data),
    .busy(busy), .spike_out(spike_out), .acc_out(acc_out),
    .prediction(prediction), .err(err), .done(done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > ACC_MAX) ? ACC_MAX : x;
  endfunction

  // Reference: features, spikes, word schedule, saturated sums and argmax from plain arithmetic.
  task automatic model_run();
    int  f [N_IN];
    bit  sp [N_IN];
    int  sum [N_OUT];
    bit  need;
    int  b, k, raw, w, c;
    e_addr.delete();
    e_spk = 0;
    for (int i = 0; i < N_IN; i++) begin
      b     = int'((m_in >> (8 * i)) & 32'hFF);
      f[i]  = (b >> 4) + (b & 15);
      sp[i] = f[i] > 1;
      if (sp[i]) e_spk = e_spk | (1 << i);
    end
    for (int j = 0; j < N_OUT; j++) e_acc[j] = 0;
    for (int n = 0; n < NW; n++) begin
      need = 1'b1;
`ifdef SNN_SPIKE_SKIP_EN
      need = 1'b0;
      for (int s = 0; s < WPW; s++) begin
        k = n * WPW + s;
        if (k < N_IN * N_OUT && sp[k / N_OUT]) need = 1'b1;
      end
`endif
      if (need) begin
        e_addr.push_back(n);
        for (int j = 0; j < N_OUT; j++) sum[j] = 0;
        for (int s = 0; s < WPW; s++) begin
          k = n * WPW + s;
          if (k < N_IN * N_OUT) begin
            raw = (int'(mem[n]) >> (4 * (WPW - 1 - s))) & 15;
            w   = (raw >= 8) ? raw - 16 : raw;
            if (sp[k / N_OUT]) begin
              c = (w >= 0) ? sat(f[k / N_OUT] * (1 << w)) : (f[k / N_OUT] >> (-w));
              sum[k % N_OUT] += c;
            end
          end
        end
        for (int j = 0; j < N_OUT; j++) e_acc[j] = sat(e_acc[j] + sum[j]);
      end
    end
    e_pred = 0;
    for (int j = 1; j < N_OUT; j++) if (e_acc[j] > e_acc[e_pred]) e_pred = j;
    e_lat = 2 * e_addr.size() + 3;
  endtask

  // Weight memory: answers each request after mem_dly extra cycles with a one-cycle w_valid.
  initial begin
    logic [ADDR_W-1:0] a;
    w_valid = 1'b0;
    w_data  = '0;
    forever begin
      @(negedge clk);
      if (w_req === 1'b1) begin
        a = w_addr;
        req_log.push_back(int'(a));
        if (mem_on) begin
          repeat (mem_dly) @(posedge clk);
          @(posedge clk); #1;
          w_valid = 1'b1;
          w_data  = mem[a];
          @(posedge clk); #1;
          w_valid = 1'b0;
          w_data  = '0;
        end
      end
    end
  end

  task automatic set_words(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_w_req"},  32'(w_req), 0);
    chk({tag, "_w_addr"}, 32'(w_addr), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_spike"},  32'(spike_out), 0);
    chk({tag, "_acc"},    32'(acc_out), 0);
    chk({tag, "_pred"},   32'(prediction), 0);
    chk({tag, "_err"},    32'(err), 0);
    chk({tag, "_done"},   32'(done), 0);
  endtask

  task automatic run_txn(input logic [31:0] inv, input int poke, output int lat);
    int cyc;
    m_in = inv;
    model_run();
    req_log.delete();
    @(negedge clk);
    in_vec = inv;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    chk("busy_after_start", 32'(busy), 1);
    chk("err_cleared", 32'(err), 0);
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
      if (cyc == poke) in_vec = $urandom();
    end
    start = 1'b0;
    lat = cyc;
    chk("done_seen", 32'(done), 1);
    chk("latency", cyc, e_lat + mem_dly * e_addr.size());
    chk("busy_at_done", 32'(busy), 0);
    chk("err", 32'(err), 0);
    chk("spike_out", 32'(spike_out), e_spk);
    chk("acc0", 32'(acc_out[ACC_W-1:0]), e_acc[0]);
    chk("acc1", 32'(acc_out[2*ACC_W-1:ACC_W]), e_acc[1]);
    chk("prediction", 32'(prediction), e_pred);
    chk("n_requests", req_log.size(), e_addr.size());
    for (int n = 0; n < e_addr.size() && n < req_log.size(); n++)
      chk("req_addr", req_log[n], e_addr[n]);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int         lat, cyc, n_high, n_done, n_bad;
    logic [7:0] b;
    logic [31:0] inv;
    rst = 1'b1; start = 1'b0; in_vec = '0;
    mem_on = 1'b1; mem_dly = 0;
    for (int a = 0; a < 64; a++) mem[a] = 8'h00;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

    set_words(8'h1F, 8'hAA, 8'h55, 8'h02);
    run_txn(32'h2201_0012, 0, lat);
    chk("s1_acc0", 32'(acc_out[ACC_W-1:0]), 10);
    chk("s1_acc1", 32'(acc_out[2*ACC_W-1:ACC_W]), 17);
    chk("s1_pred", 32'(prediction), 1);
    chk("s1_spikes", 32'(spike_out), 32'b1001);
`ifdef SNN_SPIKE_SKIP_EN
    chk("s1_latency", lat, 7);
`else
    chk("s1_latency", lat, 11);
`endif

    set_words(8'h11, 8'h00, 8'h00, 8'h00);
    run_txn(32'h2201_0012, 0, lat);
    chk("tie_pred", 32'(prediction), 0);

    set_words(8'h77, 8'h77, 8'h77, 8'h77);
    run_txn(32'hFFFF_FFFF, 0, lat);
    chk("sat_acc0", 32'(acc_out[ACC_W-1:0]), 4095);
    chk("sat_acc1", 32'(acc_out[2*ACC_W-1:ACC_W]), 4095);

    set_words(8'h1F, 8'hAA, 8'h55, 8'h02);
    run_txn(32'h2201_0012, 4, lat);

    // Timeout: no answer to the first request.
    mem_on = 1'b0;
    @(negedge clk); in_vec = 32'h2201_0012; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (w_req !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("to_req_seen", 32'(w_req), 1);
    repeat (16) @(negedge clk);
    chk("to_err_early", 32'(err), 0);
    chk("to_done_early", 32'(done), 0);
    @(negedge clk);
    chk("to_err", 32'(err), 1);
    chk("to_done", 32'(done), 1);
    chk("to_acc", 32'(acc_out), 0);
    chk("to_pred", 32'(prediction), 0);
    chk("to_busy", 32'(busy), 0);
    n_high = 0; n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (w_req) n_high++;
      if (done) n_done++;
    end
    chk("to_no_req_after", n_high, 0);
    chk("to_single_done", n_done, 0);
    mem_on = 1'b1;
    run_txn(32'h2201_0012, 0, lat);

    // Reset in WAIT with a stray start; the delayed answer lands after reset.
    mem_dly = 6;
    @(negedge clk); in_vec = 32'h2201_0012; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (w_req !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_start_ignored", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_cleared("mid_rst");
    n_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done || w_req || err || (acc_out != '0)) n_bad++;
    end
    chk("late_valid_ignored", n_bad, 0);
    mem_dly = 0;

    for (int t = 0; t < 24; t++) begin
      for (int a = 0; a < NW; a++) mem[a] = 8'($urandom());
      for (int ch = 0; ch < N_IN; ch++) begin
        case ($urandom_range(0, 3))
          0:       b = 8'h00;
          1:       b = 8'h01;
          default: b = 8'($urandom());
        endcase
        inv[ch*IN_W +: IN_W] = b;
      end
      mem_dly = $urandom_range(0, 3);
      run_txn(inv, (t % 4 == 0) ? 2 : 0, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
